probe_capture_buf: RTL and testbench
====================================

PROBE_CAPTURE_BUF -- requirements
Module: probe_capture_buf

Interface
REQ-001 SHALL have parameter PROBE_W, default 19, meaning the probe vector width (1..256).
REQ-002 SHALL have parameter DEPTH, default 256, meaning the sample buffer depth (power of two, 8..4096).
REQ-003 SHALL have parameter TRIG_POS, default 64, meaning the number of pre-trigger samples kept (0..DEPTH-1).
REQ-004 SHALL have port clk  input  1  meaning the sole clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning the synchronous, active-low reset.
REQ-006 SHALL have port probe  input  PROBE_W  meaning the signals sampled once per clk.
REQ-007 SHALL have port trig_mask  input  PROBE_W  meaning 1 = bit takes part in trigger compare.
REQ-008 SHALL have port trig_value  input  PROBE_W  meaning the required value of the masked bits.
REQ-009 SHALL have port arm  input  1  meaning a one-cycle pulse that starts a capture.
REQ-010 SHALL have port abort  input  1  meaning return to IDLE from any state.
REQ-011 SHALL have port rd_valid / rd_data[PROBE_W] / rd_last  output  meaning the readout stream; rd_ready  input  1  meaning sink accepts.
REQ-012 SHALL have port busy, triggered, done  output  1 each  meaning status flags.

Function
REQ-013 SHALL implement states IDLE, FILL, WAIT, POST, DONE; busy = 1 in FILL, WAIT, POST.
REQ-014 SHALL, in IDLE on arm=1, go to FILL (or to WAIT directly if TRIG_POS=0); arm SHALL be ignored in all other states.
REQ-015 SHALL write probe into the buffer every cycle in FILL, WAIT and POST, with a write pointer wrapping modulo DEPTH.
REQ-016 SHALL leave FILL for WAIT after exactly TRIG_POS samples are written; the trigger is not evaluated in FILL.
REQ-017 SHALL define match as ((probe ^ trig_value) & trig_mask) == 0; trig_mask = 0 matches on the first WAIT cycle.
REQ-018 SHALL, on match in WAIT, store that sample as trigger sample, set triggered, and enter POST.
REQ-019 SHALL write exactly DEPTH-TRIG_POS samples including the trigger sample, then enter DONE and set done.
REQ-020 SHALL, in DONE, stream DEPTH samples oldest first, the trigger sample at index TRIG_POS, with rd_last on index DEPTH-1.
REQ-021 SHALL assert rd_valid no later than 2 cycles after entering DONE; a transfer occurs when rd_valid and rd_ready are both high.
REQ-022 SHALL hold rd_data and rd_last stable while rd_valid=1 and rd_ready=0, and sustain one transfer per cycle while rd_ready=1.
REQ-023 SHALL return to IDLE the cycle after the rd_last transfer, clearing done and triggered.
REQ-024 SHALL, when abort=1 in any state, return to IDLE next cycle with rd_valid, busy, triggered, done = 0; abort takes priority over arm and over a match in the same cycle.
REQ-025 SHALL keep probe sampling with zero input-to-buffer bubbles: a match in the final WAIT cycle SHALL NOT drop that sample.

Reset
REQ-026 SHALL, on rst_n=0 at a clk edge, enter IDLE and drive rd_valid, rd_last, busy, triggered, done = 0 and rd_data = 0.
REQ-027 SHALL reset pointers and counters to 0 but SHALL NOT clear buffer contents; reset mid-capture or mid-readout discards the capture.

Configuration
REQ-028 SHALL support macro PROBE_CAPTURE_EDGE_TRIG_EN: when defined, the trigger fires only when match is 1 this cycle and was 0 the previous WAIT cycle; match history SHALL be cleared on entering WAIT.
REQ-029 SHALL, without PROBE_CAPTURE_EDGE_TRIG_EN, trigger on level match per REQ-017 with no history register.

Verification (PROBE_W=19, DEPTH=16, TRIG_POS=4)
REQ-030 SHALL cover: probe = cycle count, mask=0x7FFFF, value=20, arm at count 0 -> stream of 16 words 16..31, word 4 = 20, rd_last on word 15.
REQ-031 SHALL cover: mask=0 -> trigger on first WAIT sample; readout word 4 = first WAIT sample value.
REQ-032 SHALL cover: rd_ready toggling 1,0,0,1 during readout -> no word lost or duplicated, rd_data stable while stalled.
REQ-033 SHALL cover: abort asserted in the same cycle as a match in WAIT -> IDLE next cycle, triggered stays 0.
REQ-034 SHALL cover: rst_n=0 for 1 cycle during POST, then arm -> fresh capture correct, all outputs 0 during reset.
REQ-035 SHALL cover, with PROBE_CAPTURE_EDGE_TRIG_EN: probe already matching on WAIT entry and held 10 cycles, then low 1 cycle, then matching -> trigger on the second match only.

Source files
------------

// File: rtl/probe_capture_buf.sv
// Trigger-positioned probe sample buffer with a ready/valid readout stream.
// Define PROBE_CAPTURE_EDGE_TRIG_EN to trigger on a rising edge of the match instead of its level.
module probe_capture_buf #(
    parameter int PROBE_W  = 19,
    parameter int DEPTH    = 256,
    parameter int TRIG_POS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PROBE_W-1:0] probe,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic               arm,
    input  logic               abort,
    output logic               rd_valid,
    output logic [PROBE_W-1:0] rd_data,
    output logic               rd_last,
    input  logic               rd_ready,
    output logic               busy,
    output logic               triggered,
    output logic               done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CW-1:0] FILL_LAST   = CW'((TRIG_POS > 0) ? TRIG_POS - 1 : 0);
    localparam logic [CW-1:0] POST_LAST   = CW'(DEPTH - TRIG_POS - 1);
    localparam logic [CW-1:0] RD_TOTAL    = CW'(DEPTH);
    localparam logic [CW-1:0] RD_LAST_IDX = CW'(DEPTH - 1);

    logic [PROBE_W-1:0] r_mem [DEPTH];
    logic [2:0]         r_state;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      r_rd_cnt;
    logic               r_triggered;
    logic               r_rd_valid;
    logic               r_rd_last;
    logic [PROBE_W-1:0] r_rd_data;

    logic w_match;
    logic w_trig;
    logic w_write;
    logic w_load;
    logic w_xfer_last;

    assign w_match = (((probe ^ trig_value) & trig_mask) == '0);

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
    logic r_prev_match;
    logic r_hist_valid;

    // The first WAIT cycle has no predecessor, so it can never be an edge.
    assign w_trig = w_match && r_hist_valid && !r_prev_match;

    always_ff @(posedge clk) begin
        if (!rst_n || (r_state != S_WAIT)) begin
            r_prev_match <= 1'b0;
            r_hist_valid <= 1'b0;
        end else begin
            r_prev_match <= w_match;
            r_hist_valid <= 1'b1;
        end
    end
`else
    assign w_trig = w_match;
`endif

    assign w_write     = (r_state == S_FILL) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_load      = (r_state == S_DONE) && (r_rd_cnt != RD_TOTAL) && (!r_rd_valid || rd_ready);
    assign w_xfer_last = r_rd_valid && rd_ready && r_rd_last;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= probe;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rd_cnt    <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + AW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_cnt   <= '0;
                        r_state <= (TRIG_POS == 0) ? S_WAIT : S_FILL;
                    end
                end
                S_FILL: begin
                    if (r_cnt == FILL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (w_trig) begin
                        r_triggered <= 1'b1;
                        if (POST_LAST == '0) begin
                            r_state  <= S_DONE;
                            r_rptr   <= r_wptr + AW'(1);
                            r_rd_cnt <= '0;
                        end else begin
                            r_cnt   <= CW'(1);
                            r_state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (r_cnt == POST_LAST) begin
                        r_state  <= S_DONE;
                        r_rptr   <= r_wptr + AW'(1);
                        r_rd_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    // Output register doubles as the RAM read register; it only advances when empty or accepted.
                    if (w_load) begin
                        r_rd_data  <= r_mem[r_rptr];
                        r_rd_last  <= (r_rd_cnt == RD_LAST_IDX);
                        r_rd_valid <= 1'b1;
                        r_rptr     <= r_rptr + AW'(1);
                        r_rd_cnt   <= r_rd_cnt + CW'(1);
                    end else if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                    end
                    if (w_xfer_last) begin
                        r_state     <= S_IDLE;
                        r_triggered <= 1'b0;
                        r_rd_valid  <= 1'b0;
                        r_rd_last   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_last   = r_rd_last;
    assign busy      = (r_state == S_FILL) || (r_state == S_WAIT) || (r_state == S_POST);
    assign triggered = r_triggered;
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_probe_capture_buf.sv
// Scoreboard bench for probe_capture_buf: a window model pushes expected words, a monitor checks the stream.
`timescale 1ns/1ps
module tb_probe_capture_buf;
    localparam int PW = 19;
    localparam int DP = 16;
    localparam int TP = 4;
    localparam int NS = 80;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] probe;
    logic [PW-1:0] trig_mask;
    logic [PW-1:0] trig_value;
    logic          arm;
    logic          abort;
    logic          rd_valid;
    logic [PW-1:0] rd_data;
    logic          rd_last;
    logic          rd_ready;
    logic          busy;
    logic          triggered;
    logic          done;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;

    logic [PW:0]   exp_q[$];
    logic [PW-1:0] samp [NS];

    always #5 clk = ~clk;

    probe_capture_buf #(.PROBE_W(PW), .DEPTH(DP), .TRIG_POS(TP)) u_dut (
        .clk(clk), .rst_n(rst_n), .probe(probe), .trig_mask(trig_mask),
        .trig_value(trig_value), .arm(arm), .abort(abort), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready), .busy(busy),
        .triggered(triggered), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic bit is_match(input logic [PW-1:0] s, input logic [PW-1:0] m, input logic [PW-1:0] v);
        return ((s ^ v) & m) == '0;
    endfunction

    // Index of the trigger sample within samp[] (sample 0 is the first one after arm).
    function automatic int find_trig(input logic [PW-1:0] m, input logic [PW-1:0] v);
        for (int i = TP; i < NS; i++) begin
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
            if (i > TP && is_match(samp[i], m, v) && !is_match(samp[i-1], m, v)) return i;
`else
            if (is_match(samp[i], m, v)) return i;
`endif
        end
        return -1;
    endfunction

    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: rd_ready = 1'b1;
                1: rd_ready = ($urandom_range(0, 2) != 0);
                default: rd_ready = ~rd_ready ? 1'b1 : ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b0;
            endcase
        end
    end

    // Pattern 1,0,0,1 for ready_mode 2 is produced by this phase counter overriding the above.
    int rphase = 0;
    always @(posedge clk) begin
        if (ready_mode == 2) rphase <= rphase + 1;
        else rphase <= 0;
    end

    logic          stalled = 1'b0;
    logic [PW-1:0] hold_d;
    logic          hold_l;
    always @(negedge clk) begin
        logic [PW:0] e;
        if (rst_n && rd_valid) begin
            if (stalled) begin
                chk("stall_data", rd_data, hold_d);
                chk("stall_last", rd_last, hold_l);
            end
            if (rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e[PW-1:0]);
                    chk("rd_last", rd_last, e[PW]);
                end
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold_d  = rd_data;
                hold_l  = rd_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic fill_count();
        for (int i = 0; i < NS; i++) samp[i] = PW'(i + 1);
    endtask

    task automatic fill_random(input logic [PW-1:0] m, input logic [PW-1:0] v);
        int j;
        for (int i = 0; i < NS; i++) samp[i] = PW'($urandom);
        j = $urandom_range(TP + 1, 50);
        samp[j-1] = (samp[j-1] & ~m) | (~v & m);
        samp[j]   = (samp[j] & ~m) | (v & m);
    endtask

    task automatic capture(input logic [PW-1:0] m, input logic [PW-1:0] v,
                           input int abort_at, input int rst_at, input bit rnd_arm);
        int k;
        int w;
        k = find_trig(m, v);
        if (k < 0 || k + DP - TP > NS) begin
            checks++;
            errors++;
            $display("FAIL model_window actual=%0d required=valid", k);
            return;
        end
        if (abort_at < 0 && rst_at < 0) begin
            for (int j = 0; j < DP; j++) exp_q.push_back({(j == DP - 1), samp[k - TP + j]});
        end
        @(posedge clk);
        #1;
        arm = 1'b1;
        trig_mask = m;
        trig_value = v;
        probe = PW'($urandom);
        for (int i = 0; i <= k + DP - TP; i++) begin
            @(posedge clk);
            #1;
            arm = rnd_arm && ($urandom_range(0, 5) == 0);
            if (abort_at >= 0 && i == abort_at + 1) begin
                abort = 1'b0;
                arm = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_triggered", triggered, 0);
                chk("abort_done", done, 0);
                chk("abort_rd_valid", rd_valid, 0);
                return;
            end
            if (rst_at >= 0 && i == rst_at + 1) begin
                arm = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_triggered", triggered, 0);
                chk("rst_done", done, 0);
                chk("rst_rd_valid", rd_valid, 0);
                chk("rst_rd_last", rd_last, 0);
                chk("rst_rd_data", rd_data, 0);
                rst_n = 1'b1;
                return;
            end
            if (i == 0) chk("busy_after_arm", busy, 1);
            if (i == k) chk("trig_before_match", triggered, 0);
            if (i == k + 1) chk("trig_after_match", triggered, 1);
            abort = (i == abort_at);
            if (i == rst_at) rst_n = 1'b0;
            if (i < k + DP - TP) begin
                probe = samp[i];
            end else begin
                probe = PW'($urandom);
                chk("done_entry", done, 1);
                chk("busy_in_done", busy, 0);
            end
        end
        arm = 1'b0;
        w = 0;
        while ((exp_q.size() != 0 || done) && w < 400) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 400) begin
            checks++;
            errors++;
            $display("FAIL readout_timeout actual=%0d words_left required=0", exp_q.size());
            exp_q.delete();
        end
        chk("done_cleared", done, 0);
        chk("trig_cleared", triggered, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        logic [PW-1:0] m;
        logic [PW-1:0] v;
        rst_n = 1'b0;
        probe = '0;
        trig_mask = '0;
        trig_value = '0;
        arm = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_last", rd_last, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;

        fill_count();
        capture(19'h7FFFF, 19'd20, -1, -1, 1'b0);

`ifndef PROBE_CAPTURE_EDGE_TRIG_EN
        fill_random(19'h0, 19'h0);
        capture(19'h0, PW'($urandom), -1, -1, 1'b0);
`endif

        ready_mode = 2;
        m = PW'($urandom) | PW'(1);
        v = PW'($urandom);
        fill_random(m, v);
        capture(m, v, -1, -1, 1'b0);
        ready_mode = 0;

        fill_count();
        capture(19'h7FFFF, 19'd10, 9, -1, 1'b0);

        fill_count();
        capture(19'h7FFFF, 19'd30, -1, 32, 1'b0);
        ready_mode = 1;
        fill_count();
        capture(19'h7FFFF, 19'd12, -1, -1, 1'b0);

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
        v = PW'($urandom);
        for (int i = 0; i < NS; i++) samp[i] = ~v;
        for (int i = TP; i < TP + 10; i++) samp[i] = v;
        samp[TP + 11] = v;
        capture(19'h7FFFF, v, -1, -1, 1'b0);
`endif

        for (int t = 0; t < 6; t++) begin
            m = PW'($urandom) | PW'(1);
            v = PW'($urandom);
            fill_random(m, v);
            capture(m, v, -1, -1, 1'b1);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overrides rd_ready in ready_mode 2 with the fixed 1,0,0,1 pattern.
    always @(posedge clk) begin
        if (ready_mode == 2) begin
            #2;
            rd_ready = (rphase % 4 == 0) || (rphase % 4 == 3);
        end
    end

endmodule
